// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package seg_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}; all ones turns every segment off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs for codes 0-9 and A,b,C,d,E,F; dp bit left off.
  localparam logic [15:0][7:0] SEG_PATTERNS = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [0:0] {
    SHOW,
    DEAD
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder with decimal point and dark override.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_dp,
  input  logic       i_dark,
  output logic [7:0] o_seg
);

  // A dark digit turns off everything, including its decimal point.
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_dark) begin
      o_seg = SEG_PATTERNS[i_code];
      if (i_dp) begin
        o_seg[7] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one tube lit at a time, per-slot dead time,
// blink, leading-zero suppression and a per-frame snapshot of all inputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEAD_CYC     = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic [N_DIGITS-1:0]   blink_i,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   tube_pos,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned DIV_W    = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W    = $clog2(N_DIGITS);
  localparam int unsigned BLK_W    = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned SHOW_CYC = SCAN_DIV - DEAD_CYC;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] SHOW_LAST = DIV_W'(SHOW_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  // Scan position and FSM
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;
  scan_state_t      r_state;
  scan_state_t      w_state_d;

  // Blink timing
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  // Frame snapshot
  logic [4*N_DIGITS-1:0] r_snap_digits;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic [N_DIGITS-1:0]   r_snap_blank;
  logic [N_DIGITS-1:0]   r_snap_blink;
  logic                  r_snap_lz;

  // Registered outputs
  logic [N_DIGITS-1:0] r_tube;
  logic [7:0]          r_seg;
  logic                r_frame_done;

  // Combinational helpers
  logic                  w_capture;
  logic                  w_frame_end;
  logic [4*N_DIGITS-1:0] w_src_digits;
  logic [N_DIGITS-1:0]   w_src_dp;
  logic [N_DIGITS-1:0]   w_src_blank;
  logic [N_DIGITS-1:0]   w_src_blink;
  logic                  w_src_lz;
  logic [N_DIGITS-1:0]   w_lz;
  logic [3:0]            w_code;
  logic                  w_dp;
  logic                  w_dark;
  logic [7:0]            w_seg_dec;
  logic [N_DIGITS-1:0]   w_tube_d;
  logic [7:0]            w_seg_d;

  assign w_capture   = (r_idx == '0) && (r_div == '0);
  assign w_frame_end = (r_idx == IDX_LAST) && (r_div == DIV_LAST);

  // The capture cycle already computes tube 0's output, so it reads the live inputs
  // that are being written into the snapshot at the same edge.
  assign w_src_digits = w_capture ? digits_i : r_snap_digits;
  assign w_src_dp     = w_capture ? dp_i     : r_snap_dp;
  assign w_src_blank  = w_capture ? blank_i  : r_snap_blank;
  assign w_src_blink  = w_capture ? blink_i  : r_snap_blink;
  assign w_src_lz     = w_capture ? lz_en    : r_snap_lz;

  // Leading-zero mask: walk down from the top digit while everything seen is zero or blank.
  always_comb begin
    logic chain;
    w_lz  = '0;
    chain = w_src_lz;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (chain && (w_src_digits[4*k +: 4] == 4'h0) && !w_src_dp[k]) begin
        w_lz[k] = 1'b1;
      end
      chain = chain && ((w_src_digits[4*k +: 4] == 4'h0) || w_src_blank[k]) && !w_src_dp[k];
    end
  end

  // Select the digit in the current slot and work out whether it is dark.
  always_comb begin
    w_code = w_src_digits[4*r_idx +: 4];
    w_dp   = w_src_dp[r_idx];
    w_dark = w_src_blank[r_idx] || (w_src_blink[r_idx] && r_blink_phase) || w_lz[r_idx];
  end

  seg7_decode u_decode (
    .i_code (w_code),
    .i_dp   (w_dp),
    .i_dark (w_dark),
    .o_seg  (w_seg_dec)
  );

  // Slot divider and digit index; idx wraps straight back to 0 after the last tube.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SHOW;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state plus next output values for the current slot position.
  always_comb begin
    w_state_d = r_state;
    w_tube_d  = '1;
    w_seg_d   = SEG_BLANK;
    unique case (r_state)
      SHOW: begin
        w_tube_d = ~(N_DIGITS'(1) << r_idx);
        w_seg_d  = w_seg_dec;
        if ((DEAD_CYC != 0) && (r_div == SHOW_LAST)) begin
          w_state_d = DEAD;
        end
      end
      DEAD: begin
        if (r_div == DIV_LAST) begin
          w_state_d = SHOW;
        end
      end
      default: begin
        w_state_d = SHOW;
      end
    endcase
  end

  // Snapshot all display inputs once per frame so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_blank  <= '0;
      r_snap_blink  <= '0;
      r_snap_lz     <= 1'b0;
    end else if (w_capture) begin
      r_snap_digits <= digits_i;
      r_snap_dp     <= dp_i;
      r_snap_blank  <= blank_i;
      r_snap_blink  <= blink_i;
      r_snap_lz     <= lz_en;
    end
  end

  // Blink phase flips every BLINK_FRAMES frames, only at frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tube       <= '1;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_tube       <= w_tube_d;
      r_seg        <= w_seg_d;
      r_frame_done <= w_frame_end;
    end
  end

  assign tube_pos   = r_tube;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 8-cycle slots, 2 dead cycles).
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 8;
  localparam int unsigned DC = 2;
  localparam int unsigned BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic [3:0]  blink_i = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  tube_pos;
  logic [7:0]  seg;
  logic        frame_done;

  seg_scan_driver #(
    .N_DIGITS     (ND),
    .SCAN_DIV     (SD),
    .DEAD_CYC     (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .blank_i    (blank_i),
    .blink_i    (blink_i),
    .lz_en      (lz_en),
    .tube_pos   (tube_pos),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tube;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tmo = 0;
  logic done = 1'b0;
  logic rst_seen = 1'b0;

  always @(posedge clk) rst_seen <= rst;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation at the start of each lit slot and holds it for the slot.
  exp_t       cur;
  logic [3:0] prev_tube = 4'hF;
  logic       tracking = 1'b0;
  int         on_len = 0;
  int         slot_no = 0;
  int         since_fd = 0;
  logic       fd_valid = 1'b0;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL watchdog: got %0d cycles, expected under 20000", cyc);
      $fatal(1, "bench watchdog expired");
    end
    if (rst_seen) begin
      check("reset_tube", {4'h0, tube_pos}, 8'h0F);
      check("reset_seg", seg, 8'hFF);
      check("reset_frame_done", {7'h0, frame_done}, 8'h00);
      tracking = 1'b0;
      fd_valid = 1'b0;
      since_fd = 0;
    end else begin
      since_fd++;
      if (frame_done) begin
        if (fd_valid) check("frame_period", since_fd[7:0], 8'd32);
        fd_valid = 1'b1;
        since_fd = 0;
      end
      if (tube_pos != 4'hF && prev_tube == 4'hF) begin
        if (sb.size() != 0) begin
          cur      = sb.pop_front();
          tracking = 1'b1;
          on_len   = 1;
          slot_no++;
          check($sformatf("slot%0d_tube", slot_no), {4'h0, tube_pos}, {4'h0, cur.tube});
          check($sformatf("slot%0d_seg", slot_no), seg, cur.seg);
        end
      end else if (tube_pos != 4'hF) begin
        on_len++;
        if (tracking) begin
          check($sformatf("slot%0d_tube_hold", slot_no), {4'h0, tube_pos}, {4'h0, cur.tube});
          check($sformatf("slot%0d_seg_hold", slot_no), seg, cur.seg);
        end
      end else if (prev_tube != 4'hF && tracking) begin
        check($sformatf("slot%0d_on_len", slot_no), on_len[7:0], 8'd6);
        check($sformatf("slot%0d_dead_seg", slot_no), seg, 8'hFF);
        tracking = 1'b0;
      end
    end
    prev_tube = tube_pos;
    if (done) begin
      check("scoreboard_empty", 8'(sb.size()), 8'd0);
      check("wait_timeouts", 8'(tmo), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
    end
  end

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                        input logic [3:0] bk, input logic lz);
    digits_i = d;
    dp_i     = dp;
    blank_i  = bl;
    blink_i  = bk;
    lz_en    = lz;
  endtask

  // Expected segs listed for idx 0..3 (tubes E, D, B, 7).
  task automatic push4(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] s3);
    sb.push_back('{tube: 4'hE, seg: s0});
    sb.push_back('{tube: 4'hD, seg: s1});
    sb.push_back('{tube: 4'hB, seg: s2});
    sb.push_back('{tube: 4'h7, seg: s3});
  endtask

  // frame_done marks the capture cycle; inputs set here land in the next frame.
  task automatic wait_fd();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    tmo++;
  endtask

  task automatic wait_tube(input logic [3:0] t);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tube_pos == t) return;
    end
    tmo++;
  endtask

  task automatic frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                       input logic [3:0] bk, input logic lz, input logic [7:0] s0,
                       input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    wait_fd();
    set_in(d, dp, bl, bk, lz);
    push4(s0, s1, s2, s3);
  endtask

  initial begin
    // F1: plain 1234
    set_in(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
    rst = 1'b0;
    // F2: leading zeros suppressed on digits 3 and 2
    frame(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 8'hC0, 8'h92, 8'hFF, 8'hFF);
    // F3..F7: blink digit 0; phase is 1 for F3,F4,F7 and 0 for F5,F6
    frame(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0, 8'hFF, 8'hB0, 8'hA4, 8'hF9);
    frame(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0, 8'hFF, 8'hB0, 8'hA4, 8'hF9);
    frame(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    frame(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    frame(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0, 8'hFF, 8'hB0, 8'hA4, 8'hF9);
    // F8: change to 5678 while digit 2 is lit; this frame stays 1234
    frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    wait_tube(4'hB);
    digits_i = 16'h5678;
    // F9: new digits appear
    frame(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0, 8'h80, 8'hF8, 8'h82, 8'h92);
    // F10: only slots 0 and 1 complete before reset lands during digit 2
    wait_fd();
    sb.push_back('{tube: 4'hE, seg: 8'h80});
    sb.push_back('{tube: 4'hD, seg: 8'hF8});
    wait_tube(4'hB);
    rst = 1'b1;
    @(negedge clk);
    // F11: fresh snapshot after reset; dp on digit 1, digit 3 blanked (its dp stays off)
    set_in(16'h1234, 4'b1010, 4'b1000, 4'h0, 1'b0);
    push4(8'h99, 8'h30, 8'hA4, 8'hFF);
    rst = 1'b0;
    // F12: all zero, dp on digit 2 stops suppression there
    frame(16'h0000, 4'b0100, 4'h0, 4'h0, 1'b1, 8'hC0, 8'hC0, 8'h40, 8'hFF);
    // F13: blanked top digit keeps the zero run going; digit 0 always shown
    frame(16'h7003, 4'h0, 4'b1000, 4'h0, 1'b1, 8'hB0, 8'hFF, 8'hFF, 8'hFF);
    wait_fd();
    done = 1'b1;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed 7-segment scan driver; next generation of the clock's fixed 8-digit scanner. Takes N packed 4-bit digit codes plus per-digit DP/blank/blink controls. Drives one active-low digit enable at a time with decoded active-low segments. Adds an internal scan divider, anti-ghosting dead time, blink, leading-zero suppression and tear-free frame snapshot. Sits between the timekeeping/alarm-setting logic and the board tube pins.

Parameters:
N_DIGITS, 8, number of tubes scanned (2..16)
SCAN_DIV, 100000, clk cycles per digit slot (> DEAD_CYC+1)
DEAD_CYC, 16, cycles at the end of each slot with all tubes off
BLINK_FRAMES, 64, full frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
digits_i  in  4*N_DIGITS  digit codes; digit k = [4k+3:4k]; digit 0 = rightmost
dp_i  in  N_DIGITS  decimal point on per digit
blank_i  in  N_DIGITS  force digit dark
blink_i  in  N_DIGITS  digit dark during blink-off phase
lz_en  in  1  leading-zero suppression enable
tube_pos  out  N_DIGITS  active-low one-hot digit enable
seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
frame_done  out  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (rst=1 at posedge): tube_pos=all 1, seg=8'hFF, frame_done=0, div=0, idx=0, blink_phase=0, blink counter=0, state=SHOW, snapshot registers cleared to 0.
- All outputs are registered. No idle slot: idx wraps N_DIGITS-1 -> 0 directly.
- div counts 0..SCAN_DIV-1 per slot, then wraps and idx increments.
- FSM SHOW: div < SCAN_DIV-DEAD_CYC. tube_pos = ~(1<<idx); seg = decode of snapshot digit idx.
- FSM DEAD: remaining DEAD_CYC cycles. tube_pos = all 1; seg = 8'hFF.
- Snapshot: digits_i/dp_i/blank_i/blink_i/lz_en are captured together in the cycle where idx=0 and div=0. The first frame after reset captures in the first cycle after rst deasserts. Mid-frame input changes are invisible until the next frame.
- Output latency: in the capture cycle outputs still show reset/previous values. Tube 0 asserts with new data on the following clock.
- Decode: 0-9 numerals; A,b,C,d,E,F for 10-15. Blanked digit = 7'h7F on segments; its dp bit is also off.
- Digit dark if blank bit set, OR (blink bit set AND blink_phase=1), OR leading-zero suppressed.
- Leading-zero suppression (lz_en=1): digit k is suppressed if its code is 0 and every digit above k is code 0 or blanked. Digit 0 is never LZ-suppressed. A digit with dp set stops suppression at and below it.
- Dark digits still consume their full slot, so brightness stays uniform.
- frame_done=1 for exactly the last cycle of slot N_DIGITS-1, i.e. the cycle with div=SCAN_DIV-1.
- blink counter increments on each frame_done. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles in the same cycle.
- rst mid-frame: next cycle outputs are at reset values; the scan restarts from digit 0 with a fresh snapshot.

Decomposition:
- Package seg_pkg: SEG_BLANK=8'hFF, the 16-entry segment pattern constants, typedef scan_state_t {SHOW, DEAD}.
- One combinational sub-module seg7_decode: 4-bit code + dp + dark -> 8-bit active-low seg.
- Counters, FSM, snapshot and LZ logic stay in seg_scan_driver.

Test Plan:
- Bench params: N_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2.
- Reset then digits_i=16'h1234, all controls 0 -> tube_pos cycles E,D,B,7. Each slot is 6 cycles on then 2 cycles at F. seg shows 8'hF9 (digit 0 = 4?) -> check per-index: idx0=4 (8'h99), idx1=3 (8'hB0), idx2=2 (8'hA4), idx3=1 (8'hF9). frame_done pulses every 32 cycles.
- digits_i=16'h0050, lz_en=1 -> digits 3 and 2 dark (seg FF, tube still enabled); digit 1 shows 5 (8'h92); digit 0 shows 0 (8'hC0).
- blink_i=4'b0001, digits 16'h1234 -> digit 0 shows 4 for 2 frames, dark for 2 frames, repeating. Other digits are steady.
- Change digits_i 16'h1234 -> 16'h5678 at idx=2 mid-frame -> digits 2 and 3 still show 2,1 this frame; the next frame shows 8,7,6,5.
- Assert rst during idx=2 SHOW -> next cycle tube_pos=F, seg=FF; after release, the scan restarts at idx 0 with a new snapshot. dp_i=4'b0010 -> digit 1 seg bit7=0.
